// File: rtl/osd_ring_pkg.sv
// Shared types and constants for the ring router ingress path.
// RING_ROUTER_DEMUX_BCAST_EN (optional) makes the WORM_BCAST state reachable in ring_router_demux.
package osd_ring_pkg;

  localparam int               DI_ADDR_WIDTH = 16;
  localparam logic [15:0]      DI_BCAST_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WORM_LOCAL  = 2'd1,
    WORM_RING   = 2'd2,
    WORM_BCAST  = 2'd3
  } route_state_e;

  typedef struct packed {
    logic                     last;
    logic [DI_ADDR_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/ring_router_demux_if.sv
// dii_channel: valid/last/data flit link with ready backpressure.
// Used by ring_router_demux; RING_ROUTER_DEMUX_BCAST_EN does not change this interface.
interface dii_channel;
  import osd_ring_pkg::*;

  logic                     valid;
  logic                     last;
  logic [DI_ADDR_WIDTH-1:0] data;
  logic                     ready;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);

endinterface

// File: rtl/ring_router_demux_fifo2.sv
// dii_fifo2: two-entry flit FIFO with registered occupancy and a combinational head.
// Independent of RING_ROUTER_DEMUX_BCAST_EN.
module dii_fifo2
  import osd_ring_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  fifo_entry_t i_entry,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  fifo_entry_t r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_mem[r_rd_ptr];

  // Guard against over/underflow so a misbehaving caller cannot corrupt the count.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/ring_router_demux.sv
// Ring router ingress: buffers incoming worms and steers each one to the local port or onward ring.
// Define RING_ROUTER_DEMUX_BCAST_EN to deliver head address 16'hFFFF worms to both outputs.
module ring_router_demux
  import osd_ring_pkg::*;
#(
  parameter logic [DI_ADDR_WIDTH-1:0] ID         = 16'h0000,
  parameter int                       DATA_WIDTH = 16
)
(
  input  logic       clk,
  input  logic       rst_n,
  dii_channel.slave  in_ring,
  dii_channel.master out_local,
  dii_channel.master out_ring
);

  route_state_e r_state;
  route_state_e w_state_nxt;
  route_state_e w_dst;
  fifo_entry_t  w_entry;
  fifo_entry_t  w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_lv;
  logic         w_rv;
  logic         w_acc_local;
  logic         w_acc_ring;

  assign in_ring.ready = rst_n && !w_full;
  assign w_push        = in_ring.valid && in_ring.ready;
  assign w_entry.last  = in_ring.last;
  assign w_entry.data  = in_ring.data;

  dii_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // In IDLE the head is decoded every cycle; inside a worm the state itself is the destination.
  always_comb begin
    w_dst = r_state;
    if (r_state == IDLE) begin
      if (w_head.data == ID) begin
        w_dst = WORM_LOCAL;
`ifdef RING_ROUTER_DEMUX_BCAST_EN
      end else if (w_head.data == DI_BCAST_ADDR) begin
        w_dst = WORM_BCAST;
`endif
      end else begin
        w_dst = WORM_RING;
      end
    end
  end

`ifdef RING_ROUTER_DEMUX_BCAST_EN
  logic r_sent_local;
  logic r_sent_ring;

  always_comb begin
    w_lv = 1'b0;
    w_rv = 1'b0;
    if (!w_empty) begin
      case (w_dst)
        WORM_LOCAL: w_lv = 1'b1;
        WORM_RING:  w_rv = 1'b1;
        WORM_BCAST: begin
          w_lv = !r_sent_local;
          w_rv = !r_sent_ring;
        end
        default: ;
      endcase
    end
  end

  assign w_acc_local = w_lv && out_local.ready;
  assign w_acc_ring  = w_rv && out_ring.ready;

  // A broadcast flit leaves only once each copy has been taken, in whatever order.
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      if (w_dst == WORM_BCAST) begin
        w_pop = (r_sent_local || w_acc_local) && (r_sent_ring || w_acc_ring);
      end else begin
        w_pop = w_acc_local || w_acc_ring;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_pop) begin
      r_sent_local <= 1'b0;
      r_sent_ring  <= 1'b0;
    end else begin
      if (w_acc_local) r_sent_local <= 1'b1;
      if (w_acc_ring)  r_sent_ring  <= 1'b1;
    end
  end
`else
  always_comb begin
    w_lv = 1'b0;
    w_rv = 1'b0;
    if (!w_empty) begin
      case (w_dst)
        WORM_LOCAL: w_lv = 1'b1;
        WORM_RING:  w_rv = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_acc_local = w_lv && out_local.ready;
  assign w_acc_ring  = w_rv && out_ring.ready;
  assign w_pop       = w_acc_local || w_acc_ring;
`endif

  assign out_local.valid = w_lv;
  assign out_local.last  = w_lv ? w_head.last : 1'b0;
  assign out_local.data  = w_lv ? w_head.data : '0;
  assign out_ring.valid  = w_rv;
  assign out_ring.last   = w_rv ? w_head.last : 1'b0;
  assign out_ring.data   = w_rv ? w_head.data : '0;

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop) begin
      w_state_nxt = w_head.last ? IDLE : w_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  a_local_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_local.valid && !out_local.ready) |=>
      (out_local.valid && $stable(out_local.data[DATA_WIDTH-1:0]) && $stable(out_local.last)));

  a_ring_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_ring.valid && !out_ring.ready) |=>
      (out_ring.valid && $stable(out_ring.data[DATA_WIDTH-1:0]) && $stable(out_ring.last)));

`ifndef RING_ROUTER_DEMUX_BCAST_EN
  a_one_output: assert property (@(posedge clk) disable iff (!rst_n)
    !(out_local.valid && out_ring.valid));
`endif

endmodule

// File: tb/tb_ring_router_demux.sv
// Directed bench for ring_router_demux (ID=16'h0005); broadcast rows apply when RING_ROUTER_DEMUX_BCAST_EN is defined.
module tb_ring_router_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dii_channel in_ring ();
  dii_channel out_local ();
  dii_channel out_ring ();

  ring_router_demux #(.ID(16'h0005), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ring   (in_ring),
    .out_local (out_local),
    .out_ring  (out_ring)
  );

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic        il;
    logic [15:0] id;
    logic        lr;
    logic        rr;
    logic        chk;
    logic        e_ir;
    logic        e_lv;
    logic        e_ll;
    logic [15:0] e_ld;
    logic        e_rv;
    logic        e_rl;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic il, input logic [15:0] id,
                              input logic lr, input logic rr, input logic c, input logic ir,
                              input logic lv, input logic ll, input logic [15:0] ld,
                              input logic rv, input logic rl, input logic [15:0] rd);
    vec_t v;
    v.rst_n = r;  v.iv = iv;  v.il = il;  v.id = id;  v.lr = lr;  v.rr = rr;
    v.chk = c;    v.e_ir = ir;
    v.e_lv = lv;  v.e_ll = ll; v.e_ld = ld;
    v.e_rv = rv;  v.e_rl = rl; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  function automatic logic [15:0] burst_data(input int i);
    return (i % 2 == 0) ? 16'h0005 : (16'h0200 + 16'(i));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev;
    in_ring.valid   = 1'b0;
    in_ring.last    = 1'b0;
    in_ring.data    = 16'h0000;
    out_local.ready = 1'b1;
    out_ring.ready  = 1'b1;

    // reset
    vecs.push_back(mk(0,0,0,16'h0000,1,1,0, 0, 0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000,1,1,1, 0, 0,0,16'h0000, 0,0,16'h0000));
    // local worm 0005,1234,ABCD(last)
    vecs.push_back(mk(1,1,0,16'h0005,1,1,1, 1, 0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(1,1,0,16'h1234,1,1,1, 1, 1,0,16'h0005, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'hABCD,1,1,1, 1, 1,0,16'h1234, 0,0,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 1, 1,1,16'hABCD, 0,0,16'h0000));
    // ring worm 0007,1111(last) then single flit 0005
    vecs.push_back(mk(1,1,0,16'h0007,1,1,1, 1, 0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'h1111,1,1,1, 1, 0,0,16'h0000, 1,0,16'h0007));
    vecs.push_back(mk(1,1,1,16'h0005,1,1,1, 1, 0,0,16'h0000, 1,1,16'h1111));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 1, 1,1,16'h0005, 0,0,16'h0000));
    // local backpressure for 4 cycles
    vecs.push_back(mk(1,1,0,16'h0005,1,1,1, 1, 0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(1,1,0,16'h0001,1,1,1, 1, 1,0,16'h0005, 0,0,16'h0000));
    vecs.push_back(mk(1,1,0,16'h0002,0,1,1, 1, 1,0,16'h0001, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'h0003,0,1,1, 0, 1,0,16'h0001, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'h0003,0,1,1, 0, 1,0,16'h0001, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'h0003,0,1,1, 0, 1,0,16'h0001, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'h0003,1,1,1, 0, 1,0,16'h0001, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'h0003,1,1,1, 1, 1,0,16'h0002, 0,0,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 1, 1,1,16'h0003, 0,0,16'h0000));
    // ring worm interrupted by reset, then a local single flit
    vecs.push_back(mk(1,1,0,16'h0007,1,1,1, 1, 0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(1,1,0,16'h0001,1,1,1, 1, 0,0,16'h0000, 1,0,16'h0007));
    vecs.push_back(mk(1,1,0,16'h0002,1,1,1, 1, 0,0,16'h0000, 1,0,16'h0001));
    vecs.push_back(mk(0,0,0,16'h0000,1,1,0, 0, 0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(1,1,1,16'h0005,1,1,1, 1, 0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 1, 1,1,16'h0005, 0,0,16'h0000));
    // head FFFF worm with ring backpressure
    vecs.push_back(mk(1,1,0,16'hFFFF,1,1,1, 1, 0,0,16'h0000, 0,0,16'h0000));
`ifdef RING_ROUTER_DEMUX_BCAST_EN
    vecs.push_back(mk(1,1,1,16'h00AA,1,0,1, 1, 1,0,16'hFFFF, 1,0,16'hFFFF));
    vecs.push_back(mk(1,0,0,16'h0000,1,0,1, 0, 0,0,16'h0000, 1,0,16'hFFFF));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 0, 0,0,16'h0000, 1,0,16'hFFFF));
    vecs.push_back(mk(1,0,0,16'h0000,1,0,1, 1, 1,1,16'h00AA, 1,1,16'h00AA));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 1, 0,0,16'h0000, 1,1,16'h00AA));
`else
    vecs.push_back(mk(1,1,1,16'h00AA,1,0,1, 1, 0,0,16'h0000, 1,0,16'hFFFF));
    vecs.push_back(mk(1,0,0,16'h0000,1,0,1, 0, 0,0,16'h0000, 1,0,16'hFFFF));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 0, 0,0,16'h0000, 1,0,16'hFFFF));
    vecs.push_back(mk(1,0,0,16'h0000,1,0,1, 1, 0,0,16'h0000, 1,1,16'h00AA));
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 1, 0,0,16'h0000, 1,1,16'h00AA));
`endif
    vecs.push_back(mk(1,0,0,16'h0000,1,1,1, 1, 0,0,16'h0000, 0,0,16'h0000));

    foreach (vecs[r]) begin
      @(negedge clk);
      rst_n           = vecs[r].rst_n;
      in_ring.valid   = vecs[r].iv;
      in_ring.last    = vecs[r].il;
      in_ring.data    = vecs[r].id;
      out_local.ready = vecs[r].lr;
      out_ring.ready  = vecs[r].rr;
      #1;
      chk("in_ready", r, {15'd0, in_ring.ready}, {15'd0, vecs[r].e_ir});
      if (vecs[r].chk) begin
        chk("local_valid", r, {15'd0, out_local.valid}, {15'd0, vecs[r].e_lv});
        chk("ring_valid", r, {15'd0, out_ring.valid}, {15'd0, vecs[r].e_rv});
        if (vecs[r].e_lv) begin
          chk("local_data", r, out_local.data, vecs[r].e_ld);
          chk("local_last", r, {15'd0, out_local.last}, {15'd0, vecs[r].e_ll});
        end
        if (vecs[r].e_rv) begin
          chk("ring_data", r, out_ring.data, vecs[r].e_rd);
          chk("ring_last", r, {15'd0, out_ring.last}, {15'd0, vecs[r].e_rl});
        end
      end
    end

    // back-to-back single-flit packets alternating local/ring at full rate
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      in_ring.valid   = (i < 8);
      in_ring.last    = 1'b1;
      in_ring.data    = (i < 8) ? burst_data(i) : 16'h0000;
      out_local.ready = 1'b1;
      out_ring.ready  = 1'b1;
      #1;
      chk("burst_in_ready", 100 + i, {15'd0, in_ring.ready}, 16'd1);
      if (i > 0) begin
        prev = burst_data(i - 1);
        if (prev == 16'h0005) begin
          chk("burst_local_valid", 100 + i, {15'd0, out_local.valid}, 16'd1);
          chk("burst_local_data", 100 + i, out_local.data, prev);
          chk("burst_ring_idle", 100 + i, {15'd0, out_ring.valid}, 16'd0);
        end else begin
          chk("burst_ring_valid", 100 + i, {15'd0, out_ring.valid}, 16'd1);
          chk("burst_ring_data", 100 + i, out_ring.data, prev);
          chk("burst_local_idle", 100 + i, {15'd0, out_local.valid}, 16'd0);
        end
      end
    end
    @(negedge clk);
    in_ring.valid = 1'b0;
    #1;
    chk("drain_local_valid", 200, {15'd0, out_local.valid}, 16'd0);
    chk("drain_ring_valid", 200, {15'd0, out_ring.valid}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_router_demux.md
Name: ring_router_demux

Overview:
- Ingress stage of a ring router; sits directly upstream of the ring/local merge stage.
- Accepts DI packets (worms) from the incoming ring link.
- Buffers flits in a 2-entry FIFO.
- Steers each whole worm, based on its head flit's destination, either to the local endpoint or onward to the ring merge stage.
- Routing decision is held until the flit marked last has been delivered.

Parameters:
- ID, 16'h0000, node address of this router; head flit data equal to ID is routed local.
- DATA_WIDTH, 16, flit data width; fixed by the dii_channel definition, exposed only for the assertions.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_ring  dii_channel slave  valid/last 1, data 16, ready 1  flits arriving from the previous router.
- out_local  dii_channel master  valid/last 1, data 16, ready 1  flits destined to this node's endpoint.
- out_ring  dii_channel master  valid/last 1, data 16, ready 1  flits to be forwarded; feeds the ring input of the merge stage.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FIFO count cleared to 0; route state set to IDLE.
  - Any in-flight worm is discarded.
  - in_ring.ready=0 while rst_n=0.
  - out_local.valid=0 and out_ring.valid=0 from the first cycle after reset.
- FIFO: 2 entries, each holding {last, data}.
  - in_ring.ready = (count < 2), derived from registered count only.
  - Push on in_ring.valid & in_ring.ready.
  - Pop when the current head flit has been accepted by every output it must go to.
  - Push and pop in the same cycle leave count unchanged.
  - count==0: both out valids low.
  - count==2: in_ring.ready low.
- Latency: a flit accepted at edge N is presented on an output from the cycle after edge N. Sustained throughput is 1 flit/cycle when the downstream ready stays high.
- Route FSM: states IDLE, WORM_LOCAL, WORM_RING (plus WORM_BCAST with the optional feature).
  - IDLE, head present: decode head data. data==ID selects local, else ring. Only the selected output's valid is driven, combinationally from the FIFO head in the same cycle. Output data/last mirror the head.
  - IDLE, head popped with last=0: go to the selected WORM_* state.
  - IDLE, head popped with last=1: single-flit packet; stay in IDLE.
  - IDLE, head not popped (ready=0): stay in IDLE; re-decode the same head next cycle. The decision is stable because the head is unchanged.
  - WORM_x: every flit goes to output x regardless of its data; the unselected output's valid stays 0.
  - Exit WORM_x to IDLE on pop of a flit with last=1.
- Valid/data/last on an output hold stable while valid=1 and ready=0.
- The unselected output's data/last are don't-care; drive 0.

Optional Feature:
- Macro: RING_ROUTER_DEMUX_BCAST_EN.
- Defined:
  - Head data == 16'hFFFF selects broadcast; state WORM_BCAST for multi-flit worms.
  - Each flit is offered on both outputs. Registered flags sent_local/sent_ring record acceptance; an output whose flag is set drops its valid.
  - Pop occurs when both copies are accepted, whether in the same cycle or in different cycles. Both flags clear on pop.
  - Exit to IDLE on pop of a last flit.
  - Broadcast loop termination on the ring is not this block's responsibility.
- Not defined: 16'hFFFF is an ordinary address. It routes ring unless ID==16'hFFFF. No sent flags are synthesised.

Decomposition:
- Package osd_ring_pkg holds:
  - Constants: DI_ADDR_WIDTH=16, DI_BCAST_ADDR=16'hFFFF.
  - Typedef of the route state enum.
  - Typedef of the FIFO entry struct {last, data}.
- Sub-module dii_fifo2: the 2-entry flit FIFO with registered count, push/pop, head outputs and full/empty.
- The router FSM and output steering stay in ring_router_demux.

Test Plan:
- ID=16'h0005. Worm {0005, 1234, ABCD(last)} with both readies high → out_local carries 3 flits on consecutive cycles, 1 cycle after each accept; out_ring.valid never asserted.
- Worm {0007, 1111(last)} → both flits on out_ring; after the last pop the FSM is in IDLE. An immediately following single flit {0005, last} appears on out_local the next cycle.
- out_local.ready=0 for 4 cycles mid-worm → FIFO fills (count=2); in_ring.ready drops the cycle after the second push; no flit is lost or duplicated and order is preserved once ready returns.
- Worm to 0007 has 2 flits delivered, then rst_n=0 for one cycle → outputs invalid, count=0; the next worm headed 0005 routes local, not continuing the old ring worm.
- With RING_ROUTER_DEMUX_BCAST_EN, worm {FFFF, 00AA(last)}, out_ring.ready low for 2 cycles → each flit is delivered to local immediately and to ring later; each local copy is delivered exactly once; pop only after the ring accept.
- Without the macro, head FFFF (ID=0005) → routed only to out_ring.
